pipe_dmem_bytelane: RTL and testbench
=====================================

Name: pipe_dmem_bytelane

Overview:
- Parametrised single-port data memory for the pipeline CPU MEM stage.
- Successor to the fixed 32-bit word-only data memory. Adds:
  - configurable depth
  - byte, half and word stores with byte-lane enables
  - sign- or zero-extended sub-word loads
  - registered one-cycle read with a valid strobe
  - misaligned-access detection

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, 16 to 65536.
- AW, 10: word-index width, equal to log2(DEPTH).
- INIT_ZERO, 1: 1 means the memory array is zeroed at time 0 (simulation/FPGA init). Reset never clears the array.

Ports:
- clka  in  1  Clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- en  in  1  Access request this cycle.
- wea  in  1  1 = store, 0 = load; ignored when en=0.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- sext  in  1  Loads only: 1 = sign-extend, 0 = zero-extend.
- addra  in  32  Byte address.
- dina  in  32  Store data; sub-word data taken from the low bits.
- douta  out  32  Load result, registered.
- dvalid  out  1  1 for one cycle when douta carries a fresh load result.
- misalign  out  1  1 for one cycle after a rejected misaligned access.

Behaviour:
- Reset
  - When rst=1 at an edge: douta=0, dvalid=0, misalign=0.
  - Any store presented in the same cycle is suppressed.
  - Array contents are preserved.
  - rst has priority over en.
- Addressing
  - Word index = addra[AW+1:2].
  - Bits above AW+1 are ignored, so addresses wrap modulo DEPTH*4.
  - Lane = addra[1:0].
- Alignment
  - Half with addra[0]=1 is misaligned.
  - Word or reserved size with addra[1:0]≠0 is misaligned.
  - A misaligned access performs no write.
  - At the next edge: misalign=1, dvalid=0, douta=0.
- Stores (en=1, wea=1, aligned)
  - Write at the edge, little-endian lanes.
  - Byte: lane k gets dina[7:0]; only that byte is written.
  - Half: lanes {1,0} or {3,2} get dina[15:0].
  - Word: all four lanes get dina.
  - Unselected bytes are unchanged.
  - After the edge: dvalid=0, misalign=0, douta holds its previous value.
- Loads (en=1, wea=0, aligned)
  - The word is read at edge N.
  - After edge N: douta holds the lane-selected, extended value; dvalid=1.
  - Latency is exactly 1 cycle; back-to-back loads give one result per cycle.
  - Byte result: mem byte k, bits 31:8 filled with sext ? bit7 : 0.
  - Half result: selected halfword, bits 31:16 filled with sext ? bit15 : 0.
  - Word result: the full word; sext is ignored.
- Idle (en=0)
  - dvalid=0, misalign=0, douta holds its value, no write.
- Read-after-write
  - A load in the cycle directly after a store to the same word returns the updated bytes.
  - Single port: a store and a load never occur in the same cycle.
- Extension arithmetic
  - Extension is pure bit replication on the registered path; there is no arithmetic overflow case.
  - Unknown (X) inputs on size/sext are not required to be handled.

Test Plan:
- Word store 0xDEADBEEF at addra=0x14, then word load at 0x14 → one cycle later douta=0xDEADBEEF, dvalid=1 for exactly one cycle.
- Byte store 0x7F at 0x15, then byte load at 0x15:
  - with sext=1 → douta=0x0000007F
  - word load at 0x14 → 0xDEAD7FEF
  - byte load at 0x17 with sext=1 → 0xFFFFFFDE; with sext=0 → 0x000000DE
- Half load at 0x16, sext=1 → 0xFFFFDEAD. Half store 0x1234 at 0x16, then word load at 0x14 → 0x12347FEF.
- Misaligned: word store 0xFFFFFFFF at 0x15 → misalign=1 for one cycle, dvalid=0, and a later word load at 0x14 still returns 0x12347FEF. Half load at 0x13 → misalign=1, douta=0.
- Wrap-around with DEPTH=1024: store 0xA5A5A5A5 at 0x1000 (wraps to word 0), then load at 0x0 → 0xA5A5A5A5.
- Reset mid-operation: assert rst for one cycle together with a word store of 0x55 to 0x20:
  - after the edge, douta=0 and dvalid=0
  - a later load at 0x20 returns the previous contents (0 with INIT_ZERO=1)
  - four back-to-back loads at 0x0, 0x4, 0x8, 0xC give dvalid high for four consecutive cycles with the correct data.

Source files
------------

// File: rtl/pipe_dmem_bytelane_if.sv
// Bus between the MEM stage and its data memory.
//   en       access request this cycle
//   wea      1 = store, 0 = load
//   size     00 byte, 01 half, 10 word, 11 reserved (word)
//   sext     sign-extend sub-word loads
//   addra    byte address
//   dina     store data (sub-word data in the low bits)
//   douta    registered load result
//   dvalid   one-cycle strobe marking a fresh load result
//   misalign one-cycle strobe after a rejected misaligned access
// The master modport is the requester (CPU/bench); slave is the memory.
interface pipe_dmem_bytelane_if;
  logic        en;
  logic        wea;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic        dvalid;
  logic        misalign;

  modport master (
    output en, wea, size, sext, addra, dina,
    input  douta, dvalid, misalign
  );

  modport slave (
    input  en, wea, size, sext, addra, dina,
    output douta, dvalid, misalign
  );
endinterface

// File: rtl/pipe_dmem_bytelane.sv
// Single-port byte-lane data memory for the pipeline MEM stage.
// Supports byte/half/word stores with lane enables, sign- or zero-extended
// sub-word loads with a registered one-cycle read and valid strobe, and
// detection of misaligned accesses (which are dropped).
// Ports:
//   clka  clock, all state updates on the rising edge
//   rst   synchronous active-high reset (clears outputs, never the array)
//   bus   pipe_dmem_bytelane_if.slave request/response bundle
// Parameters:
//   DEPTH     number of 32-bit words (power of two, 16..65536)
//   AW        log2(DEPTH)
//   INIT_ZERO 1 = array starts zeroed at time 0
module pipe_dmem_bytelane #(
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                        clka,
  input  logic                        rst,
  pipe_dmem_bytelane_if.slave         bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  // Time-zero contents come from the declaration initialiser, so FPGA flows
  // pick them up as the bitstream init value.
  logic [31:0] mem_q [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : {32{1'bx}})};

  logic [31:0] douta_q, douta_d;
  logic        dvalid_q, dvalid_d;
  logic        misalign_q, misalign_d;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          misaligned;
  logic          do_store;
  logic          do_load;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;

  // Address bits above the word index are ignored so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addra[31:AW+2];

  assign idx  = bus.addra[AW+1:2];
  assign lane = bus.addra[1:0];

  // Reserved size 11 behaves exactly like a word access.
  assign misaligned = ((bus.size == SZ_HALF) && lane[0]) ||
                      (bus.size[1] && (lane != 2'b00));

  assign do_store = bus.en &&  bus.wea && !misaligned;
  assign do_load  = bus.en && !bus.wea && !misaligned;

  // Lane enables and replicated write data: each lane sees the right slice
  // of dina, so the write loop needs no per-lane muxing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    byte_en = 4'b1111;
    wdata   = bus.dina;
    case (bus.size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wdata   = {4{bus.dina[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{bus.dina[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection and extension feeding the output register.
  always_comb begin
    rd_word   = mem_q[idx];
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (bus.size)
      SZ_BYTE: load_data = {{24{bus.sext & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = {{16{bus.sext & rd_half[15]}}, rd_half};
      default: ;
    endcase
  end

  always_comb begin
    douta_d    = douta_q;
    dvalid_d   = 1'b0;
    misalign_d = 1'b0;
    if (bus.en && misaligned) begin
      douta_d    = '0;
      misalign_d = 1'b1;
    end else if (do_load) begin
      douta_d  = load_data;
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clka) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      douta_q    <= '0;
      dvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      douta_q    <= douta_d;
      dvalid_q   <= dvalid_d;
      misalign_q <= misalign_d;
    end
  end

  // NOTE: the array has no reset branch; resetting it would stop RAM
  // inference and the contents must survive rst anyway. rst only gates
  // the write enable.
  always_ff @(posedge clka) begin
    if (do_store && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign bus.douta    = douta_q;
  assign bus.dvalid   = dvalid_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_pipe_dmem_bytelane.sv
// Self-checking bench for pipe_dmem_bytelane (DEPTH=1024).
// Every driven cycle pushes the outputs expected after its edge into a
// scoreboard queue; a negedge monitor pops and compares them.
module tb_pipe_dmem_bytelane;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  typedef struct {
    string       tag;
    logic        dv;
    logic        mis;
    logic [31:0] dout;
  } exp_t;

  logic clka;
  logic rst;
  pipe_dmem_bytelane_if bus ();

  pipe_dmem_bytelane #(.DEPTH(1024), .AW(10), .INIT_ZERO(1'b1)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus.slave)
  );

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fails = 0;
  logic [31:0] last_dout = '0;

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus; the expected outputs follow from the interface
  // rules, with the load value supplied by the caller.
  task automatic op(input logic r, input logic e, input logic w, input logic [1:0] sz,
                    input logic sx, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] ld_exp, input string tag);
    exp_t x;
    logic mis;
    rst       = r;
    bus.en    = e;
    bus.wea   = w;
    bus.size  = sz;
    bus.sext  = sx;
    bus.addra = a;
    bus.dina  = d;
    mis = ((sz == H) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    x.tag = tag;
    if (r) begin
      x.dv = 1'b0; x.mis = 1'b0; x.dout = '0; last_dout = '0;
    end else if (!e || (w && !mis)) begin
      x.dv = 1'b0; x.mis = 1'b0; x.dout = last_dout;
    end else if (mis) begin
      x.dv = 1'b0; x.mis = 1'b1; x.dout = '0; last_dout = '0;
    end else begin
      x.dv = 1'b1; x.mis = 1'b0; x.dout = ld_exp; last_dout = ld_exp;
    end
    sb.push_back(x);
    @(posedge clka);
    #1;
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                    input string tag);
    op(1'b0, 1'b1, 1'b1, sz, 1'b0, a, d, '0, tag);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                    input logic [31:0] exp, input string tag);
    op(1'b0, 1'b1, 1'b0, sz, sx, a, '0, exp, tag);
  endtask

  task automatic idle(input string tag);
    op(1'b0, 1'b0, 1'b0, W, 1'b0, '0, '0, '0, tag);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clka);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check({x.tag, ".dvalid"},   {31'b0, bus.dvalid},   {31'b0, x.dv});
        check({x.tag, ".misalign"}, {31'b0, bus.misalign}, {31'b0, x.mis});
        check({x.tag, ".douta"},    bus.douta,             x.dout);
      end
    end
  end

  initial begin
    int left;
    rst = 1'b1;
    bus.en = 1'b0; bus.wea = 1'b0; bus.size = W; bus.sext = 1'b0;
    bus.addra = '0; bus.dina = '0;

    op(1'b1, 1'b0, 1'b0, W, 1'b0, '0, '0, '0, "reset0");
    op(1'b1, 1'b0, 1'b0, W, 1'b0, '0, '0, '0, "reset1");

    // Word store then load, followed by idle: dvalid for exactly one cycle.
    st(W, 32'h14, 32'hDEADBEEF, "st_w14");
    ld(W, 1'b0, 32'h14, 32'hDEADBEEF, "ld_w14");
    idle("idle_hold");

    // Byte lane store and sub-word loads with both extensions.
    st(B, 32'h15, 32'h0000007F, "st_b15");
    ld(B, 1'b1, 32'h15, 32'h0000007F, "ld_b15_s");
    ld(W, 1'b0, 32'h14, 32'hDEAD7FEF, "ld_w14_b");
    ld(B, 1'b1, 32'h17, 32'hFFFFFFDE, "ld_b17_s");
    ld(B, 1'b0, 32'h17, 32'h000000DE, "ld_b17_z");
    ld(B, 1'b1, 32'h14, 32'hFFFFFFEF, "ld_b14_s");
    ld(H, 1'b1, 32'h16, 32'hFFFFDEAD, "ld_h16_s");
    ld(H, 1'b0, 32'h16, 32'h0000DEAD, "ld_h16_z");
    ld(H, 1'b1, 32'h14, 32'h00007FEF, "ld_h14_s");

    // Half store with read-after-write on the next cycle.
    st(H, 32'h16, 32'hFFFF1234, "st_h16");
    ld(W, 1'b1, 32'h14, 32'h12347FEF, "ld_w14_raw");

    // Misaligned accesses are rejected and write nothing.
    st(W, 32'h15, 32'hFFFFFFFF, "st_w15_mis");
    idle("idle_after_mis");
    ld(W, 1'b0, 32'h14, 32'h12347FEF, "ld_w14_kept");
    ld(H, 1'b1, 32'h13, 32'h0, "ld_h13_mis");
    st(R, 32'h16, 32'hFFFFFFFF, "st_r16_mis");
    ld(W, 1'b0, 32'h14, 32'h12347FEF, "ld_w14_kept2");

    // Reserved size acts as word; address wrap modulo 4 KiB.
    st(R, 32'h18, 32'hCAFEF00D, "st_r18");
    ld(R, 1'b1, 32'h18, 32'hCAFEF00D, "ld_r18");
    st(W, 32'h1000, 32'hA5A5A5A5, "st_w1000");
    ld(W, 1'b0, 32'h0, 32'hA5A5A5A5, "ld_w0_wrap");
    st(B, 32'h1003, 32'h000000AB, "st_b1003");
    ld(W, 1'b0, 32'hFFFFF000, 32'hABA5A5A5, "ld_wfff_wrap");

    // Reset together with a store: outputs clear, store suppressed.
    op(1'b1, 1'b1, 1'b1, W, 1'b0, 32'h20, 32'h55, '0, "rst_st20");
    ld(W, 1'b0, 32'h20, 32'h0, "ld_w20_init");

    // Back-to-back loads: four consecutive valid results.
    st(W, 32'h4, 32'h11111111, "st_w4");
    st(W, 32'h8, 32'h22222222, "st_w8");
    st(W, 32'hC, 32'h80000033, "st_wc");
    ld(W, 1'b0, 32'h0, 32'hABA5A5A5, "b2b_0");
    ld(W, 1'b0, 32'h4, 32'h11111111, "b2b_4");
    ld(W, 1'b0, 32'h8, 32'h22222222, "b2b_8");
    ld(W, 1'b0, 32'hC, 32'h80000033, "b2b_c");
    ld(H, 1'b1, 32'hE, 32'hFFFF8000, "ld_h0e_s");
    idle("idle_end");

    bus.en = 1'b0;
    @(negedge clka);
    #1;
    left = sb.size();
    check("scoreboard_drained", left, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
